// File: rtl/logic_gate_checker.sv
// Self-test sequencer for a two-input gate block: drives {a,b} through 00..11, holds each
// vector for SETTLE_CYCLES+1 clocks and compares the seven responses against the ideal table.
module logic_gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a_o,
  output logic       b_o,
  input  logic [6:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       first_fail_valid,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CYC = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cyc_q, cyc_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [1:0] fvec_q, fvec_d;
  logic [6:0] fmask_q, fmask_d;
  logic       pass_q, pass_d;

  logic       vec_a, vec_b;
  logic [6:0] expected;
  logic [6:0] mismatch;
  logic       cmp_edge;

  // Abort outranks the compare that would otherwise happen on the same edge.
  always_comb begin
    vec_a    = idx_q[1];
    vec_b    = idx_q[0];
    expected = {vec_a & vec_b, vec_a | vec_b, ~vec_a, ~(vec_a & vec_b),
                ~(vec_a | vec_b), vec_a ^ vec_b, ~(vec_a ^ vec_b)};
    mismatch = expected ^ dut_in;
    cmp_edge = (state_q == RUN) && !abort && (cyc_q == LAST_CYC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cmp_edge && (idx_q == 2'd3)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    a_o  = (state_q == RUN) ? idx_q[1] : 1'b0;
    b_o  = (state_q == RUN) ? idx_q[0] : 1'b0;
  end

  always_comb begin
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    pass_d  = pass_q;
    if ((state_q == IDLE) && start) begin
      cyc_d   = 4'd0;
      idx_d   = 2'd0;
      err_d   = 3'd0;
      ffv_d   = 1'b0;
      fvec_d  = 2'd0;
      fmask_d = 7'd0;
      pass_d  = 1'b0;
    end else if ((state_q == RUN) && !abort) begin
      if (cmp_edge) begin
        cyc_d = 4'd0;
        idx_d = idx_q + 2'd1;
        if (mismatch != 7'd0) begin
          err_d = err_q + 3'd1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            fvec_d  = idx_q;
            fmask_d = mismatch;
          end
        end
        if (idx_q == 2'd3) begin
          pass_d = (err_d == 3'd0);
        end
      end else begin
        cyc_d = cyc_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q   <= 4'd0;
      idx_q   <= 2'd0;
      err_q   <= 3'd0;
      ffv_q   <= 1'b0;
      fvec_q  <= 2'd0;
      fmask_q <= 7'd0;
      pass_q  <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
      pass_q  <= pass_d;
    end
  end

  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign fail_vec         = fvec_q;
  assign fail_mask        = fmask_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// Scoreboard bench for logic_gate_checker: a faultable gate model feeds dut_in, and each
// completed run's results and done cycle are checked against queued hand-computed values.
`timescale 1ns/1ps
module tb_logic_gate_checker;

  localparam int SC      = 2;
  localparam int WIN     = SC + 1;
  localparam int RUN_LEN = 4 * WIN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       a_o, b_o;
  logic [6:0] dut_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic       first_fail_valid;
  logic [1:0] fail_vec;
  logic [6:0] fail_mask;

  int fault_mode = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [2:0] err;
    logic       ffv;
    logic [1:0] fvec;
    logic [6:0] fmask;
  } exp_t;

  exp_t sb_q[$];

  logic_gate_checker #(.SETTLE_CYCLES(SC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .a_o              (a_o),
    .b_o              (b_o),
    .dut_in           (dut_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .fail_vec         (fail_vec),
    .fail_mask        (fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate block under test, with selectable injected faults.
  always_comb begin
    dut_in = {a_o & b_o, a_o | b_o, ~a_o, ~(a_o & b_o), ~(a_o | b_o), a_o ^ b_o, ~(a_o ^ b_o)};
    case (fault_mode)
      1: dut_in[1] = 1'b0;
      2: dut_in[4] = ~dut_in[4];
      3: if ({a_o, b_o} == 2'b00) dut_in[6] = ~dut_in[6];
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int dc, input logic p, input logic [2:0] e, input logic f,
                          input logic [1:0] fv, input logic [6:0] fk);
    exp_t x;
    x = '{dc, p, e, f, fv, fk};
    sb_q.push_back(x);
  endtask

  // Returns the cycle stamp of the accepting edge.
  task automatic accept_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 50), 32'd1);
  endtask

  task automatic full_run(input string name, input int fm, input logic p, input logic [2:0] e,
                          input logic f, input logic [1:0] fv, input logic [6:0] fk);
    int c0;
    fault_mode = fm;
    accept_start(c0);
    push_exp(c0 + RUN_LEN, p, e, f, fv, fk);
    for (int k = 0; k < RUN_LEN; k++) begin
      @(negedge clk);
      chk({name, "_busy"}, 32'(busy), 32'd1);
      chk({name, "_vec"}, 32'({a_o, b_o}), 32'(k / WIN));
    end
    @(negedge clk);
    chk({name, "_busy_in_done"}, 32'({busy, a_o, b_o}), 32'd0);
    wait_idle({name, "_idle"});
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("TXN done cyc=%0d pass=%0b err=%0d ffv=%0b vec=%02b mask=%07b",
                 cyc, pass, err_count, first_fail_valid, fail_vec, fail_mask);
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("first_fail_valid", 32'(first_fail_valid), 32'(e.ffv));
        chk("fail_vec", 32'(fail_vec), 32'(e.fvec));
        chk("fail_mask", 32'(fail_mask), 32'(e.fmask));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    #2;
    chk("reset_outputs", 32'({a_o, b_o, busy, done, pass, err_count, first_fail_valid,
                              fail_vec, fail_mask}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    full_run("good", 0, 1'b1, 3'd0, 1'b0, 2'b00, 7'b0000000);
    full_run("xor_stuck0", 1, 1'b0, 3'd2, 1'b1, 2'b01, 7'b0000010);
    full_run("not_inv", 2, 1'b0, 3'd4, 1'b1, 2'b00, 7'b0010000);

    // Reset while vector 10 is on the bus, after two compares have failed.
    fault_mode = 2;
    accept_start(c0);
    repeat (8) @(negedge clk);
    chk("pre_reset_vec", 32'({a_o, b_o}), 32'd2);
    chk("pre_reset_err", 32'(err_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({a_o, b_o, busy, done, pass, err_count, first_fail_valid,
                                    fail_vec, fail_mask}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    full_run("after_reset", 0, 1'b1, 3'd0, 1'b0, 2'b00, 7'b0000000);

    // Start re-pulsed mid-run is ignored.
    fault_mode = 0;
    accept_start(c0);
    push_exp(c0 + RUN_LEN, 1'b1, 3'd0, 1'b0, 2'b00, 7'b0000000);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("repulse_idle");

    // Start held high: next run begins two edges after the done edge.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_exp(c0 + RUN_LEN, 1'b1, 3'd0, 1'b0, 2'b00, 7'b0000000);
    push_exp(c0 + RUN_LEN + 2 + RUN_LEN, 1'b1, 3'd0, 1'b0, 2'b00, 7'b0000000);
    repeat (RUN_LEN + 1) @(posedge clk);
    #1;
    chk("held_start_gap_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("held_start_rerun_busy", 32'(busy), 32'd1);
    wait_idle("held_idle");

    // Start and abort together in IDLE: start wins. Then abort at edge 7.
    fault_mode = 3;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", 32'(busy), 32'd1);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_results", 32'({pass, err_count, first_fail_valid, fail_vec, fail_mask}),
        32'({1'b0, 3'd1, 1'b1, 2'b00, 7'b1000000}));
    repeat (2) @(negedge clk);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_held_results", 32'({busy, pass, err_count, first_fail_valid, fail_vec, fail_mask}),
        32'({1'b0, 1'b0, 3'd1, 1'b1, 2'b00, 7'b1000000}));

    // Abort landing on the compare edge of failing vector 01 discards that compare.
    fault_mode = 1;
    accept_start(c0);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_on_cmp", 32'({busy, err_count, first_fail_valid}), 32'd0);
    repeat (16) @(negedge clk);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
